// File: rtl/mst_str_gen_if.sv
// Control, request and payload signals between the pre-fetch stage and the
// streaming test-data generator.
interface mst_str_gen_if #(
    parameter int DW = 32
);
    logic [1:0]    patsel;
    logic [3:0]    chnen;
    logic          genclr;
    logic          gen0req;
    logic          gen1req;
    logic          gen2req;
    logic          gen3req;
    logic [DW-1:0] gen0dat;
    logic [DW-1:0] gen1dat;
    logic [DW-1:0] gen2dat;
    logic [DW-1:0] gen3dat;
    logic [15:0]   genreqcnt0;
    logic [15:0]   genreqcnt1;
    logic [15:0]   genreqcnt2;
    logic [15:0]   genreqcnt3;

    // Requester side (pre-fetch / host control).
    modport master (
        output patsel, chnen, genclr, gen0req, gen1req, gen2req, gen3req,
        input  gen0dat, gen1dat, gen2dat, gen3dat,
        input  genreqcnt0, genreqcnt1, genreqcnt2, genreqcnt3
    );

    // Generator side.
    modport slave (
        input  patsel, chnen, genclr, gen0req, gen1req, gen2req, gen3req,
        output gen0dat, gen1dat, gen2dat, gen3dat,
        output genreqcnt0, genreqcnt1, genreqcnt2, genreqcnt3
    );
endinterface

// File: rtl/mst_str_gen.sv
// Four-channel streaming test-data generator. Each channel keeps the next
// word to emit and a registered output word; an accepted request moves the
// next word to the output and advances it through the selected pattern.

// One generator channel; CH sets the channel id used in the seeds.
module mst_str_gen_ch #(
    parameter int          DW        = 32,
    parameter int          CH        = 0,
    parameter logic [31:0] LFSR_SEED = 32'h0000_0001,
    parameter logic [31:0] LFSR_TAPS = 32'h8020_0003,
    parameter logic [31:0] FIXPAT    = 32'hA5A5_5A5C
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    patsel,
    input  logic          en,
    input  logic          req,
    input  logic          clr,
    output logic [DW-1:0] dat,
    output logic [15:0]   cnt
);
    localparam logic [1:0]    ID       = 2'(CH);
    localparam logic [DW-1:0] INC_SEED = {ID, {(DW-2){1'b0}}};
    localparam logic [DW-1:0] LFSR_RAW = LFSR_SEED + DW'(CH);
    // A zero LFSR state would lock up, so it is replaced by 1.
    localparam logic [DW-1:0] LFSR_SD  = (LFSR_RAW == '0) ? DW'(1) : LFSR_RAW;
    localparam logic [DW-1:0] WALK_SD  = DW'(1) << CH;
    localparam logic [DW-1:0] FIX_SD   = {FIXPAT[DW-1:2], ID};

    logic [DW-1:0] nxt;
    logic [DW-1:0] nxt_f;
    logic [DW-1:0] seed;

    // Seed for the currently selected pattern, used on genclr.
    always_comb begin
        seed = INC_SEED;
        case (patsel)
            2'd0: seed = INC_SEED;
            2'd1: seed = LFSR_SD;
            2'd2: seed = WALK_SD;
            2'd3: seed = FIX_SD;
            default: seed = INC_SEED;
        endcase
    end

    // Pattern step function applied to the next word.
    always_comb begin
        nxt_f = nxt;
        case (patsel)
            2'd0: nxt_f = {nxt[DW-1:DW-2], nxt[DW-3:0] + {{(DW-3){1'b0}}, 1'b1}};
            2'd1: nxt_f = nxt[0] ? ((nxt >> 1) ^ LFSR_TAPS) : (nxt >> 1);
            2'd2: nxt_f = {nxt[DW-2:0], nxt[DW-1]};
            2'd3: nxt_f = nxt;
            default: nxt_f = nxt;
        endcase
    end

    // Channel state: genclr beats a same-cycle request; disabled channels hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nxt <= INC_SEED;
            dat <= '0;
            cnt <= '0;
        end else if (clr) begin
            nxt <= seed;
            dat <= '0;
            cnt <= '0;
        end else if (req && en) begin
            dat <= nxt;
            nxt <= nxt_f;
            cnt <= cnt + 16'd1;
        end
    end
endmodule

module mst_str_gen #(
    parameter int          DW        = 32,
    parameter logic [31:0] LFSR_SEED = 32'h0000_0001,
    parameter logic [31:0] LFSR_TAPS = 32'h8020_0003,
    parameter logic [31:0] FIXPAT    = 32'hA5A5_5A5C
) (
    input  logic              clk,
    input  logic              rst,
    mst_str_gen_if.slave      bus
);
    localparam int NCH = 4;

    logic [NCH-1:0]         req;
    logic [NCH-1:0][DW-1:0] dat;
    logic [NCH-1:0][15:0]   cnt;

    assign req = {bus.gen3req, bus.gen2req, bus.gen1req, bus.gen0req};

    assign bus.gen0dat    = dat[0];
    assign bus.gen1dat    = dat[1];
    assign bus.gen2dat    = dat[2];
    assign bus.gen3dat    = dat[3];
    assign bus.genreqcnt0 = cnt[0];
    assign bus.genreqcnt1 = cnt[1];
    assign bus.genreqcnt2 = cnt[2];
    assign bus.genreqcnt3 = cnt[3];

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        mst_str_gen_ch #(
            .DW        (DW),
            .CH        (i),
            .LFSR_SEED (LFSR_SEED),
            .LFSR_TAPS (LFSR_TAPS),
            .FIXPAT    (FIXPAT)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .patsel (bus.patsel),
            .en     (bus.chnen[i]),
            .req    (req[i]),
            .clr    (bus.genclr),
            .dat    (dat[i]),
            .cnt    (cnt[i])
        );
    end
endmodule
